// File: rtl/display_arbiter_if.sv
// Requester-side bundle for display_arbiter: request/data from the requesters,
// grant status and the BCD word back toward the display driver.
interface display_arbiter_if;
    logic [2:0]  req;
    logic [15:0] data0;
    logic [15:0] data1;
    logic [15:0] data2;
    logic [2:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] bcd_out;

    modport master (
        output req, data0, data1, data2,
        input  gnt, owner, busy, bcd_out
    );

    modport slave (
        input  req, data0, data1, data2,
        output gnt, owner, busy, bcd_out
    );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin owner of the shared 4-digit display with a minimum hold time per
// grant; every output is a flop, so requester inputs never reach the driver combinationally.
module display_arbiter #(
    parameter int          HOLD_CYCLES  = 50_000_000,
    parameter logic [15:0] IDLE_PATTERN = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    display_arbiter_if.slave  bus
);
    localparam int             CW     = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CW-1:0]  RELOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_OPEN} state_t;

    state_t         state_q, state_d;
    logic [2:0]     gnt_q, gnt_d;
    logic [1:0]     owner_q, owner_d;
    logic [1:0]     last_q, last_d;
    logic           busy_q, busy_d;
    logic [15:0]    bcd_q, bcd_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [15:0]    data_arr [3];
    logic [1:0]     nxt1, nxt2, pick;
    logic           pick_valid, owner_req, others_req, do_grant;

    assign data_arr[0] = bus.data0;
    assign data_arr[1] = bus.data1;
    assign data_arr[2] = bus.data2;

    // Search order starts just after the previous owner and ends on it.
    assign nxt1 = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    assign nxt2 = (nxt1 == 2'd2) ? 2'd0 : nxt1 + 2'd1;

    always_comb begin
        pick_valid = 1'b1;
        pick       = last_q;
        if (bus.req[nxt1])        pick = nxt1;
        else if (bus.req[nxt2])   pick = nxt2;
        else if (bus.req[last_q]) pick = last_q;
        else                      pick_valid = 1'b0;
    end

    assign owner_req  = |(bus.req & gnt_q);
    assign others_req = |(bus.req & ~gnt_q);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        last_d   = last_q;
        busy_d   = busy_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        do_grant = 1'b0;

        case (state_q)
            S_IDLE: begin
                do_grant = pick_valid;
            end
            S_HOLD: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = S_OPEN;
                // Owner that dropped req leaves its last word frozen on screen.
                if (owner_req) bcd_d = data_arr[owner_q];
            end
            S_OPEN: begin
                if (others_req) begin
                    do_grant = 1'b1;
                end else if (!owner_req) begin
                    state_d = S_IDLE;
                    gnt_d   = 3'b000;
                    owner_d = 2'd0;
                    busy_d  = 1'b0;
                    bcd_d   = IDLE_PATTERN;
                end else begin
                    bcd_d = data_arr[owner_q];
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 3'b000;
                owner_d = 2'd0;
                busy_d  = 1'b0;
                bcd_d   = IDLE_PATTERN;
                cnt_d   = '0;
            end
        endcase

        if (do_grant) begin
            gnt_d   = 3'(3'b001 << pick);
            owner_d = pick;
            last_d  = pick;
            busy_d  = 1'b1;
            cnt_d   = RELOAD;
            bcd_d   = data_arr[pick];
            state_d = (HOLD_CYCLES == 1) ? S_OPEN : S_HOLD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= 3'b000;
            owner_q <= 2'd0;
            last_q  <= 2'd2;
            busy_q  <= 1'b0;
            bcd_q   <= IDLE_PATTERN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = busy_q;
    assign bus.bcd_out = bcd_q;
endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with HOLD_CYCLES=4: reset, early drop,
// contention rotation, sole-owner persistence, pointer wrap, reset in HOLD.
module tb_display_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    display_arbiter_if bus ();

    display_arbiter #(
        .HOLD_CYCLES  (4),
        .IDLE_PATTERN (16'hFFFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed between edges.
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic release_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.req   = 3'b010;
        bus.data1 = 16'hABCD;
        step();
        checks++;
        if (bus.gnt !== 3'b010) begin
            errors++;
            $display("FAIL reset_pre_gnt: got %b want 010", bus.gnt);
        end
        pulse_reset();
        checks++;
        if (bus.gnt !== 3'b000 || bus.owner !== 2'd0 || bus.busy !== 1'b0 || bus.bcd_out !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_async: gnt=%b owner=%0d busy=%b bcd=%h want 000/0/0/ffff",
                     bus.gnt, bus.owner, bus.busy, bus.bcd_out);
        end
        bus.req = 3'b000;
        release_reset();
        step();
        checks++;
        if (bus.gnt !== 3'b000 || bus.bcd_out !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_idle_after: gnt=%b bcd=%h want 000/ffff", bus.gnt, bus.bcd_out);
        end
        $display("test_reset done");
    endtask

    task automatic test_early_drop();
        bus.req   = 3'b010;
        bus.data1 = 16'h1234;
        step();
        checks++;
        if (bus.gnt !== 3'b010 || bus.owner !== 2'd1 || bus.busy !== 1'b1 || bus.bcd_out !== 16'h1234) begin
            errors++;
            $display("FAIL drop_e0: gnt=%b owner=%0d busy=%b bcd=%h want 010/1/1/1234",
                     bus.gnt, bus.owner, bus.busy, bus.bcd_out);
        end
        bus.data1 = 16'h0101;
        step();
        checks++;
        if (bus.gnt !== 3'b010 || bus.bcd_out !== 16'h0101) begin
            errors++;
            $display("FAIL drop_e1: gnt=%b bcd=%h want 010/0101", bus.gnt, bus.bcd_out);
        end
        bus.req   = 3'b000;
        bus.data1 = 16'h5555;
        for (int e = 2; e <= 3; e++) begin
            step();
            checks++;
            if (bus.gnt !== 3'b010 || bus.busy !== 1'b1 || bus.bcd_out !== 16'h0101) begin
                errors++;
                $display("FAIL drop_frozen_e%0d: gnt=%b busy=%b bcd=%h want 010/1/0101",
                         e, bus.gnt, bus.busy, bus.bcd_out);
            end
        end
        step();
        checks++;
        if (bus.gnt !== 3'b000 || bus.owner !== 2'd0 || bus.busy !== 1'b0 || bus.bcd_out !== 16'hFFFF) begin
            errors++;
            $display("FAIL drop_e4_idle: gnt=%b owner=%0d busy=%b bcd=%h want 000/0/0/ffff",
                     bus.gnt, bus.owner, bus.busy, bus.bcd_out);
        end
        $display("test_early_drop done");
    endtask

    task automatic test_contention();
        logic [2:0]  exp_gnt;
        logic [15:0] exp_bcd;
        int          o;
        pulse_reset();
        release_reset();
        bus.data0 = 16'h0000;
        bus.data1 = 16'h1111;
        bus.data2 = 16'h2222;
        bus.req   = 3'b111;
        for (int e = 0; e < 16; e++) begin
            step();
            o = (e / 4) % 3;
            exp_gnt = 3'(1 << o);
            exp_bcd = (o == 0) ? 16'h0000 : (o == 1) ? 16'h1111 : 16'h2222;
            checks++;
            if (bus.gnt !== exp_gnt || bus.owner !== 2'(o) || bus.bcd_out !== exp_bcd) begin
                errors++;
                $display("FAIL contention_e%0d: gnt=%b owner=%0d bcd=%h want %b/%0d/%h",
                         e, bus.gnt, bus.owner, bus.bcd_out, exp_gnt, o, exp_bcd);
            end
        end
        bus.req = 3'b000;
        step();
        checks++;
        if (bus.gnt !== 3'b000 || bus.bcd_out !== 16'hFFFF) begin
            errors++;
            $display("FAIL contention_release: gnt=%b bcd=%h want 000/ffff", bus.gnt, bus.bcd_out);
        end
        $display("test_contention done");
    endtask

    task automatic test_sole_owner();
        pulse_reset();
        release_reset();
        bus.data0 = 16'h0007;
        bus.data2 = 16'h2468;
        bus.req   = 3'b001;
        for (int e = 0; e < 20; e++) begin
            bus.data0 = 16'(e);
            step();
            checks++;
            if (bus.gnt !== 3'b001 || bus.bcd_out !== 16'(e)) begin
                errors++;
                $display("FAIL sole_e%0d: gnt=%b bcd=%h want 001/%h", e, bus.gnt, bus.bcd_out, 16'(e));
            end
        end
        bus.req = 3'b101;
        step();
        checks++;
        if (bus.gnt !== 3'b100 || bus.owner !== 2'd2 || bus.bcd_out !== 16'h2468) begin
            errors++;
            $display("FAIL sole_handover: gnt=%b owner=%0d bcd=%h want 100/2/2468",
                     bus.gnt, bus.owner, bus.bcd_out);
        end
        $display("test_sole_owner done");
    endtask

    task automatic test_pointer_wrap();
        pulse_reset();
        release_reset();
        bus.data0 = 16'h0A0A;
        bus.data1 = 16'h1B1B;
        bus.data2 = 16'h2C2C;
        bus.req   = 3'b100;
        for (int e = 0; e < 4; e++) begin
            step();
            checks++;
            if (bus.gnt !== 3'b100 || bus.bcd_out !== 16'h2C2C) begin
                errors++;
                $display("FAIL wrap_own2_e%0d: gnt=%b bcd=%h want 100/2c2c", e, bus.gnt, bus.bcd_out);
            end
        end
        bus.req = 3'b011;
        step();
        checks++;
        if (bus.gnt !== 3'b001 || bus.owner !== 2'd0 || bus.bcd_out !== 16'h0A0A) begin
            errors++;
            $display("FAIL wrap_pick: gnt=%b owner=%0d bcd=%h want 001/0/0a0a",
                     bus.gnt, bus.owner, bus.bcd_out);
        end
        $display("test_pointer_wrap done");
    endtask

    task automatic test_reset_in_hold();
        logic [2:0] exp_gnt;
        pulse_reset();
        release_reset();
        bus.req = 3'b010;
        step();
        step();
        checks++;
        if (bus.gnt !== 3'b010) begin
            errors++;
            $display("FAIL rhold_pre: gnt=%b want 010", bus.gnt);
        end
        pulse_reset();
        checks++;
        if (bus.gnt !== 3'b000 || bus.busy !== 1'b0 || bus.bcd_out !== 16'hFFFF) begin
            errors++;
            $display("FAIL rhold_async: gnt=%b busy=%b bcd=%h want 000/0/ffff",
                     bus.gnt, bus.busy, bus.bcd_out);
        end
        bus.req = 3'b101;
        release_reset();
        for (int e = 0; e < 5; e++) begin
            step();
            exp_gnt = (e < 4) ? 3'b001 : 3'b100;
            checks++;
            if (bus.gnt !== exp_gnt) begin
                errors++;
                $display("FAIL rhold_seq_e%0d: gnt=%b want %b", e, bus.gnt, exp_gnt);
            end
        end
        bus.req = 3'b000;
        $display("test_reset_in_hold done");
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.req   = 3'b000;
        bus.data0 = 16'h0000;
        bus.data1 = 16'h0000;
        bus.data2 = 16'h0000;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        checks++;
        if (bus.gnt !== 3'b000 || bus.owner !== 2'd0 || bus.busy !== 1'b0 || bus.bcd_out !== 16'hFFFF) begin
            errors++;
            $display("FAIL power_on_reset: gnt=%b owner=%0d busy=%b bcd=%h want 000/0/0/ffff",
                     bus.gnt, bus.owner, bus.busy, bus.bcd_out);
        end
        test_early_drop();
        test_reset();
        test_contention();
        test_sole_owner();
        test_pointer_wrap();
        test_reset_in_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/display_arbiter.md
# display_arbiter

Shares the single 4-digit seven-segment display between three independent requesters (e.g. the sequence detector, a drive-mode status reporter, and a debug counter). It grants ownership by round-robin and enforces a minimum hold time so that a displayed value stays readable. It drives a registered 16-bit BCD word (four nibbles, digit 3 down to digit 0) that feeds the existing 4-digit BCD-to-7-segment driver. It adds no combinational path from any requester input to the driver.

## Interface
- HOLD_CYCLES, 50_000_000: minimum clock cycles a grant persists (≥1). Counter width is clog2(HOLD_CYCLES)+1.
- IDLE_PATTERN, 16'hFFFF: BCD word shown when no requester owns the display.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  3  request per requester; bit i belongs to requester i.
- data0, data1, data2  input  16 each  BCD word offered by requester 0/1/2.
- gnt  output  3  one-hot grant (all zero when idle), registered.
- owner  output  2  index of the current owner; 0 when idle, registered.
- busy  output  1  high while any grant is active, registered.
- bcd_out  output  16  word to the display driver, registered.

## Operation
- State is {busy, owner, cnt, last}. `last` is the most recent owner index and is used to set round-robin order.
- Round-robin pick: search (last+1), (last+2), (last+3) mod 3, and take the first requester whose req bit is high.
- The block has three states:
  - IDLE: busy=0.
  - HOLD: busy=1, cnt>0.
  - OPEN: busy=1, cnt==0.
- IDLE: if any req bit is high at an edge, grant the pick at that edge:
  - gnt/owner set to the pick, last ← pick;
  - cnt ← HOLD_CYCLES−1;
  - bcd_out ← data of the pick.
  - Next state is HOLD, or OPEN if HOLD_CYCLES=1.
- HOLD: cnt decrements once per edge.
  - The grant is kept regardless of req.
  - bcd_out ← owner's data at each edge where the owner's req is high. Otherwise bcd_out keeps its last value (frozen).
- OPEN: evaluated at each edge. Exactly one of the following applies:
  - Owner's req is low and another req is high: grant the pick immediately (no idle cycle), reload cnt, and load bcd_out from the new owner.
  - Owner's req is low and no other req is high: return to IDLE; gnt=0, owner=0, bcd_out ← IDLE_PATTERN.
  - Owner's req is high and another req is high: rotate to the pick (time-slice). The handling is the same as the first case.
  - Owner's req is high and no other req is high: keep the grant indefinitely and keep tracking the owner's data.
- A requester asserting req while another owns the display waits. No request is lost as long as req is held high.
- Requesters must hold req high until they see their gnt bit; a req pulse dropped before then is ignored.
- Reset (asynchronous, immediate, any state):
  - gnt=0, owner=0, busy=0;
  - bcd_out=IDLE_PATTERN, cnt=0;
  - last=2, so requester 0 has first priority after reset.

## Timing
- Grant latency: 1 edge. A req sampled high at edge e in IDLE gives gnt/bcd_out valid after edge e.
- Data latency: 1 cycle. An owner's data change is visible on bcd_out after the next edge.
- A grant issued at edge e0 cannot change before edge e0+HOLD_CYCLES. It therefore lasts at least HOLD_CYCLES cycles.
- Under full contention each slice is exactly HOLD_CYCLES cycles, with grant order 0,1,2,0,…
- Handover between requesters is gapless: gnt moves from one bit directly to another at a single edge. gnt is never two-hot.
- At a handover edge, bcd_out switches to the new owner's data at that same edge. It never shows IDLE_PATTERN.
- cnt never wraps: it saturates at 0 in OPEN.

## Test plan
All scenarios use HOLD_CYCLES=4, IDLE_PATTERN=16'hFFFF.
- Reset: assert rst mid-simulation (asynchronously, between edges) → gnt=000, owner=0, busy=0, bcd_out=16'hFFFF immediately.
- Single owner with early drop: req=010 and data1=16'h1234 at edge 0 → gnt=010, bcd_out=1234. At edge 1, data1=16'h0101 → bcd_out=0101. Drop req after edge 1 → gnt stays 010 and bcd_out stays 0101 through edge 3. At edge 4 → gnt=000, bcd_out=FFFF.
- Full contention: req=111 held, data0/1/2 = 16'h0000/1111/2222 → gnt is 001,010,100,001, each for exactly 4 cycles; bcd_out follows with no FFFF gap.
- Sole owner persists: req=001 for 20 cycles → gnt=001 for all 20 cycles. A later req2 rises at cycle 20 → gnt=100 at the next edge.
- Pointer wrap: requester 2 owns; req0 and req1 rise and req2 drops in OPEN → gnt=001 (not 010).
- Reset during HOLD, then after release req=101 → gnt=001 first, and gnt=100 after 4 cycles.
